// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and double-dabble helpers for the
// seven-segment scan controller.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK           = 8'hFF;
  localparam logic [3:0] AN_OFF              = 4'b1111;
  localparam logic [3:0] NIB_DASH            = 4'hF;
  localparam int         REFRESH_DIV_DEFAULT = 100000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // One double-dabble iteration on {bcd[11:0], bin[7:0]}: every BCD nibble
  // of 5 or more gets +3, then the whole field shifts left by one.
  function automatic logic [19:0] dd_step(input logic [19:0] sr);
    logic [19:0] t;
    t = sr;
    for (int i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5) begin
        t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
      end
    end
    return {t[18:0], 1'b0};
  endfunction

  // Unsigned magnitude of the input; -128 maps to 128 as an unsigned byte.
  function automatic logic [7:0] magnitude(input logic [7:0] value,
                                           input logic       signed_mode);
    logic [7:0] inv;
    inv = ~value;
    if (signed_mode && value[7]) begin
      return inv + 8'd1;
    end
    return value;
  endfunction

endpackage

// File: rtl/BCD_to7Seg.sv
// BCD nibble to active-low hgfedcba segment pattern. Digits 0-9 decode to
// their glyph with the decimal point off; every other code yields a dash.
module BCD_to7Seg (
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  // Pure lookup table; the default row doubles as the minus-sign glyph.
  always_comb begin
    seg = 8'b10111111;
    case (bcd)
      4'd0:    seg = 8'b11000000;
      4'd1:    seg = 8'b11111001;
      4'd2:    seg = 8'b10100100;
      4'd3:    seg = 8'b10110000;
      4'd4:    seg = 8'b10011001;
      4'd5:    seg = 8'b10010010;
      4'd6:    seg = 8'b10000010;
      4'd7:    seg = 8'b11111000;
      4'd8:    seg = 8'b10000000;
      4'd9:    seg = 8'b10010000;
      default: seg = 8'b10111111;
    endcase
  end

endmodule

// File: rtl/bin2bcd_dd.sv
// Sequential double-dabble converter: captures an 8-bit magnitude and sign
// on start, runs eight shift iterations, then presents the digits for one
// COMMIT cycle (done) before returning to IDLE.
module bin2bcd_dd
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] bin,
  input  logic       sign_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       sign
);

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  cnt_q;
  logic [19:0] sr_q;
  logic        sign_q;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == 3'd7) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Iteration counter: runs 0..7 while shifting, parked at 0 otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 3'd0;
    end else if (state_q == SHIFT) begin
      cnt_q <= cnt_q + 3'd1;
    end else begin
      cnt_q <= 3'd0;
    end
  end

  // Shift register and sign: loaded on accepted start, stepped in SHIFT.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      sr_q   <= {12'd0, bin};
      sign_q <= sign_in;
    end else if (state_q == SHIFT) begin
      sr_q   <= dd_step(sr_q);
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == COMMIT);
  assign hundreds = sr_q[19:16];
  assign tens     = sr_q[15:12];
  assign ones     = sr_q[11:8];
  assign sign     = sign_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller: converts a loaded byte to BCD,
// latches the result into display registers on commit, and multiplexes the
// digits through a single shared segment decoder.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] value,
  input  logic       load,
  input  logic       signed_mode,
  input  logic       blank_lz,
  output logic       busy,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [7:0]       mag;
  logic             conv_done;
  logic [3:0]       conv_h;
  logic [3:0]       conv_t;
  logic [3:0]       conv_o;
  logic             conv_sign;

  logic [DIV_W-1:0] div_q;
  logic [1:0]       idx_q;

  logic [3:0]       disp_h;
  logic [3:0]       disp_t;
  logic [3:0]       disp_o;
  logic             disp_sign;
  logic             shown_valid;

  logic [3:0]       nib;
  logic             blank;
  logic [3:0]       an_d;
  logic [7:0]       dec_seg;

  assign mag = magnitude(value, signed_mode);

  bin2bcd_dd u_conv (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (load),
    .bin      (mag),
    .sign_in  (signed_mode & value[7]),
    .busy     (busy),
    .done     (conv_done),
    .hundreds (conv_h),
    .tens     (conv_t),
    .ones     (conv_o),
    .sign     (conv_sign)
  );

  // Refresh divider and digit index; index steps on the divider's last count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      idx_q <= 2'd0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Display registers change only on commit, so shifting never shows through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_h      <= 4'd0;
      disp_t      <= 4'd0;
      disp_o      <= 4'd0;
      disp_sign   <= 1'b0;
      shown_valid <= 1'b0;
    end else if (conv_done) begin
      disp_h      <= conv_h;
      disp_t      <= conv_t;
      disp_o      <= conv_o;
      disp_sign   <= conv_sign;
      shown_valid <= 1'b1;
    end
  end

  // Digit steering and blanking for the currently scanned index.
  always_comb begin
    an_d  = AN_OFF;
    nib   = disp_o;
    blank = 1'b0;
    case (idx_q)
      2'd0: begin
        an_d = 4'b1110;
        nib  = disp_o;
      end
      2'd1: begin
        an_d = 4'b1101;
        nib  = disp_t;
        if (blank_lz && disp_h == 4'd0 && disp_t == 4'd0) blank = 1'b1;
      end
      2'd2: begin
        an_d = 4'b1011;
        nib  = disp_h;
        if (blank_lz && disp_h == 4'd0) blank = 1'b1;
      end
      default: begin
        an_d = 4'b0111;
        nib  = NIB_DASH;
        if (!disp_sign) blank = 1'b1;
      end
    endcase
    if (!shown_valid) blank = 1'b1;
  end

  BCD_to7Seg u_dec (
    .bcd (nib),
    .seg (dec_seg)
  );

  // Anode and segment outputs registered together so they always match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_d;
      seg <= blank ? SEG_BLANK : dec_seg;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the board's 4-digit common-anode seven-segment display. It captures an 8-bit processor result on a load strobe and converts it to three BCD digits with a sequential double-dabble. It then cycles the anodes, steering one nibble at a time through a single shared BCD_to7Seg decoder instance. It sits between the processor's output register and the display pins.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit (1 kHz per digit at 100 MHz); must be ≥ 2.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset. One clock domain.
- `value` in 8: number to display.
- `load` in 1: single-cycle capture strobe.
- `signed_mode` in 1: sampled with `load`; 1 treats `value` as two's complement.
- `blank_lz` in 1: live input; 1 blanks leading zeros.
- `busy` out 1: conversion in progress.
- `an` out 4: anodes, active-low one-hot; `an[0]` = ones digit.
- `seg` out 8: segments hgfedcba, active-low; `8'hFF` = blank.

## Operation
- FSM states:
  - IDLE: `load`=1 captures the magnitude and sign into a shift register, then goes to SHIFT. `load` in any other state is ignored.
  - SHIFT: exactly 8 cycles of add-3-then-shift-left over a 12-bit BCD field. Then goes to COMMIT.
  - COMMIT: one cycle. Copies hundreds/tens/ones and sign into the display registers, sets `shown_valid`, then returns to IDLE.
- Magnitude rule:
  - `signed_mode`=1 and `value[7]`=1: magnitude = (~value + 1), taken as unsigned 8 bits, so -128 becomes 128. Sign flag = 1.
  - Otherwise: magnitude = `value`, sign flag = 0.
- Scan:
  - A divider counts 0..REFRESH_DIV-1. At terminal count, scan index 0→1→2→3→0 advances.
  - Index 0/1/2/3 maps to `an` = 1110/1101/1011/0111.
- Nibble sent to the decoder for each index:
  - Index 0: ones.
  - Index 1: tens.
  - Index 2: hundreds.
  - Index 3: 4'hF when the sign flag is set (the decoder default gives dash `8'b10111111`), otherwise blank.
- Blanking forces `seg=8'hFF` and takes priority over the decoder output. Blanking applies when:
  - `shown_valid`=0, on all digits;
  - index 3 with sign flag = 0;
  - `blank_lz`=1 and index 2 with hundreds = 0;
  - `blank_lz`=1 and index 1 with hundreds = 0 and tens = 0.
- The ones digit is never blanked once `shown_valid`=1.
- Display registers keep the previous value during SHIFT. There is no intermediate or garbage display.

## Timing
- Reset values:
  - `an`=4'b1111, `seg`=8'hFF, `busy`=0.
  - FSM = IDLE, divider = 0, scan index = 0.
  - Display registers = 0, `shown_valid`=0.
- Scanning after reset: the first rising edge after `reset_n` deasserts drives `an`=1110. Index 0 is held REFRESH_DIV cycles, then advances.
- `an` and `seg` are registered and update on the same edge. There is no cycle in which a new anode shows old segments.
- Conversion latency, with `load` sampled at edge k:
  - `busy`=1 after edge k.
  - Display registers update at edge k+9.
  - `busy`=0 after edge k+9.
  - The new digit value appears on `seg` at the next refresh of that digit, no later than REFRESH_DIV cycles after the commit for the digit being scanned.
- `load` and COMMIT in the same cycle: `load` is ignored, because FSM ≠ IDLE.
- `blank_lz` changes take effect on the next `seg` register update.
- `reset_n` asserted mid-conversion aborts immediately. Outputs return to reset values and no partial commit occurs.

## Structure
- Package `seg_pkg` holds:
  - `SEG_BLANK`=8'hFF;
  - `AN_OFF`=4'b1111;
  - `NIB_DASH`=4'hF;
  - the FSM state enum (IDLE, SHIFT, COMMIT);
  - `REFRESH_DIV_DEFAULT`.
- Sub-module `bin2bcd_dd`: the sequential double-dabble with the start/busy/done handshake, owning the SHIFT counter. The top level keeps the scan logic, blanking, and one BCD_to7Seg instance.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset: hold `reset_n`=0 → `an`=1111, `seg`=FF, `busy`=0. After release, `an`=1110 with `seg`=FF, because nothing has been committed yet.
- `value`=173, `signed_mode`=0, `blank_lz`=0, `load` pulse:
  - `busy` is high for exactly 9 cycles.
  - Scan shows ones 8'b10110000, tens 8'b11111000, hundreds 8'b11111001, index 3 8'hFF.
- `value`=8'hF6, `signed_mode`=1, `blank_lz`=1 (-10):
  - ones 8'b11000000;
  - tens 8'b11111001;
  - hundreds 8'hFF;
  - index 3 8'b10111111.
- `value`=0, `blank_lz`=1: only the ones digit shows 8'b11000000, all others FF. Toggling `blank_lz` to 0 shows 0 on tens and hundreds.
- Load 8'h80 signed, with a second `load` of 8'd5 pulsed 3 cycles later:
  - the second load is ignored;
  - display is dash/1/2/8.
- Load 8'd99, then assert `reset_n`=0 at SHIFT cycle 4:
  - outputs return to reset values;
  - after release, `seg` stays FF on all digits until a new load commits.
